mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage of the 5-stage RV32I pipeline, directly downstream of the execute stage.
//  - Holds the EX/M and M/W pipeline registers.
//  - Drives a req/ready data-memory port with byte enables and load extraction.
//  - Stalls the pipeline on wait states and suppresses misaligned or timed-out accesses.
//  - Provides ALUResultM/RdM/RegWriteM to the hazard unit for forwarding.
// PARAMETERS
//  XLEN     32  datapath width
//  RA_W     5   register address width
//  TIMEOUT  16  max WAIT cycles before bus error (>=1)
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-high
//  RegWriteE  in   1     EX: register write enable
//  MemWriteE  in   1     EX: store
//  ResultSrcE in   3     EX: writeback select (RES_MEM = load)
//  StoreSrcE  in   2     EX: 00 sb, 01 sh, 10 sw
//  LoadSrcE   in   3     EX: funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//  ALUResultE in   XLEN  EX: result / effective address
//  WriteDataE in   XLEN  EX: forwarded rs2 store data
//  RdE        in   RA_W  EX: destination register
//  PCPlus4E   in   XLEN  EX: link value
//  ALUResultM out  XLEN  M: forwarding value
//  RdM        out  RA_W  M: destination register
//  RegWriteM  out  1     M: register write enable
//  StallM     out  1     1 = freeze IF..M (hazard unit)
//  MisalignM  out  1     1-cycle pulse: misaligned access dropped
//  BusErrM    out  1     1-cycle pulse: timeout
//  DMemReq    out  1     memory request
//  DMemWe     out  1     1 = write
//  DMemAddr   out  XLEN  word address ({ALUResultM[31:2],2'b00})
//  DMemWData  out  XLEN  lane-replicated store data
//  DMemBe     out  4     byte enables
//  DMemReady  in   1     access completes this cycle
//  DMemRData  in   XLEN  read word, valid when DMemReady
//  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W  out  -> writeback
// BEHAVIOUR
//  Reset (async, immediate): all registers and outputs 0, FSM IDLE, DMemReq=0.
//  EX/M register: loads on the clk edge when StallM=0; holds when StallM=1.
//  MemOp = MemWriteM | (ResultSrcM==RES_MEM).
//  Misaligned: (half & a[0]) or (word & a[1:0]!=0).
//   - MemOp & misaligned: DMemReq=0, MisalignM=1, no stall.
//   - The instruction retires with RegWriteW forced to 0.
//  FSM IDLE/WAIT, TIMEOUT counter:
//   IDLE: aligned MemOp -> DMemReq=1 combinationally.
//     DMemReady=1 same cycle -> zero-wait, StallM=0.
//     Else StallM=1, go WAIT, count=1.
//   WAIT: DMemReq held with address/data/be stable, StallM=1.
//     DMemReady -> StallM=0, IDLE.
//     count==TIMEOUT without ready -> BusErrM=1, DMemReq=0, StallM=0, IDLE.
//       The instruction retires with RegWriteW=0.
//  M/W register:
//   - Loads the M instruction in its completing cycle (StallM=0).
//   - During StallM=1 it loads a bubble (RegWriteW=0, others don't-care/0).
//  Store lanes:
//   - sb: WData={4{b}}, Be=1<<a[1:0]
//   - sh: WData={2{h}}, Be=a[1]?1100:0011
//   - sw: Be=1111
//   - Non-store: Be=0000.
//  Load extract: select lane by a[1:0] from DMemRData.
//   - lb/lh sign-extend; lbu/lhu zero-extend; lw passthrough.
//   - Result is registered into ReadDataW.
//   - Undefined LoadSrc values are treated as lw.
//  Non-memory instructions: pass through in 1 cycle, DMemReq=0, never stall.
// STRUCTURE
//  Package riscv_pkg:
//   - RES_MEM, store-size and load-funct3 localparams.
//   - mstate_t {IDLE,WAIT}.
//  Sub-module lsu_align: combinational store lane/Be generation and load extraction.
//  Pipeline registers and FSM live in mem_stage.
// TESTING
//  1. sw 0xDEADBEEF @0x100, ready same cycle -> Be=1111, StallM never 1, Req for 1 cycle.
//  2. lb @0x103, rdata=0x80FF_0000, ready after 3 cycles
//     -> StallM=1 for 3 cycles, W bubbles, ReadDataW=0xFFFFFF80.
//  3. lhu @0x102, rdata=0x8001_1234 -> ReadDataW=0x00008001.
//     sh 0xABCD @0x102 -> WData=0xABCDABCD, Be=1100.
//  4. lw @0x101 -> MisalignM pulse, DMemReq=0, RegWriteW=0, no stall.
//  5. lw with ready never asserted -> BusErrM at cycle TIMEOUT, StallM released, RegWriteW=0.
//  6. reset asserted in WAIT -> DMemReq=0 and outputs 0 at once.
//     After release: IDLE, next add passes in 1 cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I memory-stage definitions: writeback selects, store/load
// encodings, the memory FSM state type and access-size helpers.
package riscv_pkg;

  // Writeback select encodings (ResultSrc)
  localparam logic [2:0] RES_ALU = 3'd0;
  localparam logic [2:0] RES_MEM = 3'd1;
  localparam logic [2:0] RES_PC4 = 3'd2;

  // Store size (StoreSrc)
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  // Load funct3 (LoadSrc)
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mstate_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } msize_t;

  // Access width; unknown store/load encodings behave as full words.
  function automatic msize_t access_size(input logic       is_store,
                                         input logic [1:0] st_src,
                                         input logic [2:0] ld_src);
    msize_t sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (st_src)
        ST_SB:   sz = SZ_BYTE;
        ST_SH:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (ld_src)
        LD_LB, LD_LBU: sz = SZ_BYTE;
        LD_LH, LD_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic misaligned(input msize_t sz, input logic [1:0] a);
    return ((sz == SZ_HALF) && a[0]) || ((sz == SZ_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the data-memory port.
//  is_store_i  : M instruction is a store (selects store size encoding)
//  st_src_i    : store size, ld_src_i : load funct3
//  addr_lo_i   : effective address bits [1:0]
//  wdata_i     : rs2 store data        -> wdata_o : lane-replicated store data
//                                      -> be_o    : byte enables (0 for non-stores)
//  rdata_i     : memory read word      -> ld_data_o : extracted/extended load value
module lsu_align
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_store_i,
  input  logic [1:0]      st_src_i,
  input  logic [2:0]      ld_src_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store lane replication and byte enables
  always_comb begin : store_lanes
    wdata_o = wdata_i;
    be_o    = 4'b0000;
    if (is_store_i) begin
      case (access_size(1'b1, st_src_i, ld_src_i))
        SZ_BYTE: begin
          wdata_o = {4{wdata_i[7:0]}};
          be_o    = 4'(4'b0001 << addr_lo_i);
        end
        SZ_HALF: begin
          wdata_o = {2{wdata_i[15:0]}};
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        end
        default: be_o = 4'b1111;
      endcase
    end
  end

  // Load lane select and sign/zero extension
  always_comb begin : load_extract
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_src_i)
      LD_LB:   ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LH:   ld_data_o = {{16{half_sel[15]}}, half_sel};
      LD_LBU:  ld_data_o = {24'd0, byte_sel};
      LD_LHU:  ld_data_o = {16'd0, half_sel};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: EX/M and M/W pipeline registers, req/ready data-memory
// port with wait-state stalling, misalign suppression and bus timeout.
//  clk, reset          : clock, async active-high reset
//  *E inputs           : execute-stage controls, address, store data, rd, PC+4
//  ALUResultM/RdM/RegWriteM : M-stage values for forwarding
//  StallM              : freeze IF..M while an access waits
//  MisalignM/BusErrM   : one-cycle fault pulses (access dropped)
//  DMem*               : data-memory request port
//  *W outputs          : writeback-stage values
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [2:0]      ResultSrcE,
  input  logic [1:0]      StoreSrcE,
  input  logic [2:0]      LoadSrcE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [RA_W-1:0] RdE,
  input  logic [XLEN-1:0] PCPlus4E,
  output logic [XLEN-1:0] ALUResultM,
  output logic [RA_W-1:0] RdM,
  output logic            RegWriteM,
  output logic            StallM,
  output logic            MisalignM,
  output logic            BusErrM,
  output logic            DMemReq,
  output logic            DMemWe,
  output logic [XLEN-1:0] DMemAddr,
  output logic [XLEN-1:0] DMemWData,
  output logic [3:0]      DMemBe,
  input  logic            DMemReady,
  input  logic [XLEN-1:0] DMemRData,
  output logic            RegWriteW,
  output logic [2:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [RA_W-1:0] RdW,
  output logic [XLEN-1:0] PCPlus4W
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  // EX/M register
  logic            regwrite_m_q, memwrite_m_q;
  logic [2:0]      resultsrc_m_q, loadsrc_m_q;
  logic [1:0]      storesrc_m_q;
  logic [XLEN-1:0] aluresult_m_q, writedata_m_q, pcplus4_m_q;
  logic [RA_W-1:0] rd_m_q;

  // M/W register
  logic            regwrite_w_q;
  logic [2:0]      resultsrc_w_q;
  logic [XLEN-1:0] aluresult_w_q, readdata_w_q, pcplus4_w_q;
  logic [RA_W-1:0] rd_w_q;

  // FSM
  mstate_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            mem_op_c, is_load_c, misaligned_c;
  logic            req_c, stall_c, misalign_c, buserr_c, done_c;
  logic [XLEN-1:0] ld_data_c;

  assign mem_op_c     = memwrite_m_q | (resultsrc_m_q == RES_MEM);
  assign is_load_c    = ~memwrite_m_q & (resultsrc_m_q == RES_MEM);
  assign misaligned_c = misaligned(access_size(memwrite_m_q, storesrc_m_q, loadsrc_m_q),
                                   aluresult_m_q[1:0]);

  lsu_align #(.XLEN(XLEN)) u_align (
    .is_store_i (memwrite_m_q),
    .st_src_i   (storesrc_m_q),
    .ld_src_i   (loadsrc_m_q),
    .addr_lo_i  (aluresult_m_q[1:0]),
    .wdata_i    (writedata_m_q),
    .rdata_i    (DMemRData),
    .wdata_o    (DMemWData),
    .be_o       (DMemBe),
    .ld_data_o  (ld_data_c)
  );

  // Access FSM state register
  always_ff @(posedge clk or posedge reset) begin : fsm_reg
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Access FSM next state; ready wins over timeout in the final wait cycle
  always_comb begin : fsm_next
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    buserr_c   = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_c) begin
          if (misaligned_c) begin
            misalign_c = 1'b1;
          end else begin
            req_c = 1'b1;
            if (DMemReady) begin
              done_c = 1'b1;
            end else begin
              stall_c = 1'b1;
              state_d = WAIT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
      end
      WAIT: begin
        if (DMemReady) begin
          req_c   = 1'b1;
          done_c  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          buserr_c = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // EX/M register: frozen while the current access is stalled
  always_ff @(posedge clk or posedge reset) begin : ex_m_reg
    if (reset) begin
      regwrite_m_q  <= 1'b0;
      memwrite_m_q  <= 1'b0;
      resultsrc_m_q <= '0;
      storesrc_m_q  <= '0;
      loadsrc_m_q   <= '0;
      aluresult_m_q <= '0;
      writedata_m_q <= '0;
      rd_m_q        <= '0;
      pcplus4_m_q   <= '0;
    end else if (!stall_c) begin
      regwrite_m_q  <= RegWriteE;
      memwrite_m_q  <= MemWriteE;
      resultsrc_m_q <= ResultSrcE;
      storesrc_m_q  <= StoreSrcE;
      loadsrc_m_q   <= LoadSrcE;
      aluresult_m_q <= ALUResultE;
      writedata_m_q <= WriteDataE;
      rd_m_q        <= RdE;
      pcplus4_m_q   <= PCPlus4E;
    end
  end

  // M/W register: bubble while stalled, dropped accesses retire without a write
  always_ff @(posedge clk or posedge reset) begin : m_w_reg
    if (reset) begin
      regwrite_w_q  <= 1'b0;
      resultsrc_w_q <= '0;
      aluresult_w_q <= '0;
      readdata_w_q  <= '0;
      rd_w_q        <= '0;
      pcplus4_w_q   <= '0;
    end else if (stall_c) begin
      regwrite_w_q  <= 1'b0;
      resultsrc_w_q <= '0;
      aluresult_w_q <= '0;
      readdata_w_q  <= '0;
      rd_w_q        <= '0;
      pcplus4_w_q   <= '0;
    end else begin
      regwrite_w_q  <= regwrite_m_q & ~misalign_c & ~buserr_c;
      resultsrc_w_q <= resultsrc_m_q;
      aluresult_w_q <= aluresult_m_q;
      readdata_w_q  <= (done_c & is_load_c) ? ld_data_c : '0;
      rd_w_q        <= rd_m_q;
      pcplus4_w_q   <= pcplus4_m_q;
    end
  end

  assign ALUResultM = aluresult_m_q;
  assign RdM        = rd_m_q;
  assign RegWriteM  = regwrite_m_q;
  assign StallM     = stall_c;
  assign MisalignM  = misalign_c;
  assign BusErrM    = buserr_c;
  assign DMemReq    = req_c;
  assign DMemWe     = req_c & memwrite_m_q;
  assign DMemAddr   = {aluresult_m_q[XLEN-1:2], 2'b00};

  assign RegWriteW  = regwrite_w_q;
  assign ResultSrcW = resultsrc_w_q;
  assign ALUResultW = aluresult_w_q;
  assign ReadDataW  = readdata_w_q;
  assign RdW        = rd_w_q;
  assign PCPlus4W   = pcplus4_w_q;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;
  import riscv_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RA_W    = 5;
  localparam int unsigned TIMEOUT = 16;
  localparam int          NEVER   = 1000;

  logic            clk;
  logic            reset;
  logic            RegWriteE, MemWriteE;
  logic [2:0]      ResultSrcE, LoadSrcE;
  logic [1:0]      StoreSrcE;
  logic [XLEN-1:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [RA_W-1:0] RdE;
  logic [XLEN-1:0] ALUResultM;
  logic [RA_W-1:0] RdM;
  logic            RegWriteM, StallM, MisalignM, BusErrM;
  logic            DMemReq, DMemWe, DMemReady;
  logic [XLEN-1:0] DMemAddr, DMemWData, DMemRData;
  logic [3:0]      DMemBe;
  logic            RegWriteW;
  logic [2:0]      ResultSrcW;
  logic [XLEN-1:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [RA_W-1:0] RdW;

  mem_stage #(.XLEN(XLEN), .RA_W(RA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .StoreSrcE(StoreSrcE), .LoadSrcE(LoadSrcE), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .RdE(RdE), .PCPlus4E(PCPlus4E),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM), .StallM(StallM),
    .MisalignM(MisalignM), .BusErrM(BusErrM), .DMemReq(DMemReq), .DMemWe(DMemWe),
    .DMemAddr(DMemAddr), .DMemWData(DMemWData), .DMemBe(DMemBe),
    .DMemReady(DMemReady), .DMemRData(DMemRData),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction as seen by the memory stage plus the memory's behaviour for it
  typedef struct {
    logic        rw, mw;
    logic [2:0]  rsrc, lsrc;
    logic [1:0]  ssrc;
    logic [31:0] alu, wd, pc4, rdata;
    logic [4:0]  rd;
    int          lat;          // cycles in M before ready; >TIMEOUT means never in time
    logic        lit_rd_en;    // hand-computed ReadDataW
    logic [31:0] lit_rd;
    logic        lit_st_en;    // hand-computed store lanes
    logic [31:0] lit_wd;
    logic [3:0]  lit_be;
    int          lit_stalls;   // hand-computed stall cycles, -1 = none
  } instr_t;

  instr_t q[$];
  instr_t ex_i, m_i, w_i;
  int     age, dut_stalls;
  logic   w_bubble, w_kill, w_load_ok;
  int     vectors, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic rw, input logic mw, input logic [2:0] rs,
                                input logic [1:0] ss, input logic [2:0] ls,
                                input logic [31:0] alu, input logic [31:0] wd,
                                input logic [31:0] rdata, input int lat);
    instr_t t;
    t.rw = rw; t.mw = mw; t.rsrc = rs; t.ssrc = ss; t.lsrc = ls;
    t.alu = alu; t.wd = wd; t.rdata = rdata; t.lat = lat;
    t.rd = 5'($urandom); t.pc4 = $urandom;
    t.lit_rd_en = 1'b0; t.lit_rd = '0;
    t.lit_st_en = 1'b0; t.lit_wd = '0; t.lit_be = '0;
    t.lit_stalls = -1;
    return t;
  endfunction

  function automatic instr_t nop();
    instr_t t;
    t = mk(1'b0, 1'b0, RES_ALU, 2'b00, 3'b000, '0, '0, '0, 0);
    t.rd = '0; t.pc4 = '0;
    return t;
  endfunction

  // Number of bytes accessed
  function automatic int nbytes(input instr_t t);
    if (t.mw) return (t.ssrc == 2'b00) ? 1 : (t.ssrc == 2'b01) ? 2 : 4;
    if (t.lsrc == 3'b000 || t.lsrc == 3'b100) return 1;
    if (t.lsrc == 3'b001 || t.lsrc == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic is_memop(input instr_t t);
    return t.mw || (t.rsrc == RES_MEM);
  endfunction

  function automatic logic is_mis(input instr_t t);
    return is_memop(t) && ((t.alu % 32'(nbytes(t))) != 0);
  endfunction

  function automatic logic [31:0] exp_be(input instr_t t);
    int n;
    n = nbytes(t);
    return 32'(((1 << n) - 1) << int'(t.alu % 4));
  endfunction

  function automatic logic [31:0] exp_wd(input instr_t t);
    logic [31:0] r;
    int n;
    n = nbytes(t);
    r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = t.wd[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] load_val(input instr_t t);
    logic [31:0] w;
    int sh;
    sh = 8 * int'(t.alu % 4);
    w = t.rdata >> sh;
    case (t.lsrc)
      3'b000:  return (w[7]  ? 32'hFFFF_FF00 : 32'h0) | (w & 32'hFF);
      3'b001:  return (w[15] ? 32'hFFFF_0000 : 32'h0) | (w & 32'hFFFF);
      3'b100:  return w & 32'hFF;
      3'b101:  return w & 32'hFFFF;
      default: return t.rdata;
    endcase
  endfunction

  task automatic drive_ex(input instr_t t);
    RegWriteE = t.rw; MemWriteE = t.mw; ResultSrcE = t.rsrc;
    StoreSrcE = t.ssrc; LoadSrcE = t.lsrc; ALUResultE = t.alu;
    WriteDataE = t.wd; RdE = t.rd; PCPlus4E = t.pc4;
  endtask

  // Model state right after the first edge following reset release (M and W hold zeros)
  task automatic model_after_reset();
    m_i = nop(); w_i = nop(); ex_i = nop();
    age = 0; dut_stalls = 0;
    w_bubble = 1'b0; w_kill = 1'b0; w_load_ok = 1'b0;
    drive_ex(ex_i);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_DMemReq"}, 32'(DMemReq), 32'd0);
    chk({tag, "_StallM"}, 32'(StallM), 32'd0);
    chk({tag, "_RegWriteM"}, 32'(RegWriteM), 32'd0);
    chk({tag, "_ALUResultM"}, ALUResultM, 32'd0);
    chk({tag, "_DMemAddr"}, DMemAddr, 32'd0);
    chk({tag, "_DMemBe"}, 32'(DMemBe), 32'd0);
    chk({tag, "_RegWriteW"}, 32'(RegWriteW), 32'd0);
    chk({tag, "_ALUResultW"}, ALUResultW, 32'd0);
    chk({tag, "_ReadDataW"}, ReadDataW, 32'd0);
  endtask

  // One clock: entered just after a rising edge, returns just after the next one
  task automatic cycle();
    logic mem, mis, tmo, e_req, e_stall, e_berr;
    int   end_age;
    mem     = is_memop(m_i);
    mis     = is_mis(m_i);
    tmo     = mem && !mis && (m_i.lat > int'(TIMEOUT));
    end_age = (!mem || mis) ? 0 : (tmo ? int'(TIMEOUT) : m_i.lat);
    e_stall = age < end_age;
    e_berr  = tmo && (age == int'(TIMEOUT));
    e_req   = mem && !mis && !e_berr;
    DMemReady = mem && !mis && (age == m_i.lat);
    DMemRData = m_i.rdata;

    @(negedge clk);
    if (StallM) dut_stalls++;
    chk("StallM", 32'(StallM), 32'(e_stall));
    chk("DMemReq", 32'(DMemReq), 32'(e_req));
    chk("MisalignM", 32'(MisalignM), 32'(mis));
    chk("BusErrM", 32'(BusErrM), 32'(e_berr));
    chk("RegWriteM", 32'(RegWriteM), 32'(m_i.rw));
    chk("RdM", 32'(RdM), 32'(m_i.rd));
    chk("ALUResultM", ALUResultM, m_i.alu);
    if (e_req) begin
      chk("DMemWe", 32'(DMemWe), 32'(m_i.mw));
      chk("DMemAddr", DMemAddr, m_i.alu - (m_i.alu % 4));
      chk("DMemBe", 32'(DMemBe), m_i.mw ? exp_be(m_i) : 32'd0);
      if (m_i.mw) chk("DMemWData", DMemWData, exp_wd(m_i));
      if (m_i.lit_st_en) begin
        chk("lit_WData", DMemWData, m_i.lit_wd);
        chk("lit_Be", 32'(DMemBe), 32'(m_i.lit_be));
      end
    end
    chk("RegWriteW", 32'(RegWriteW), 32'(!w_bubble && w_i.rw && !w_kill));
    if (!w_bubble) begin
      chk("RdW", 32'(RdW), 32'(w_i.rd));
      chk("ALUResultW", ALUResultW, w_i.alu);
      chk("PCPlus4W", PCPlus4W, w_i.pc4);
      chk("ResultSrcW", 32'(ResultSrcW), 32'(w_i.rsrc));
      if (w_load_ok) chk("ReadDataW", ReadDataW, load_val(w_i));
      if (w_load_ok && w_i.lit_rd_en) chk("lit_ReadDataW", ReadDataW, w_i.lit_rd);
    end
    if (!e_stall && m_i.lit_stalls >= 0)
      chk("lit_stall_cycles", 32'(dut_stalls), 32'(m_i.lit_stalls));

    @(posedge clk);
    #1;
    if (e_stall) begin
      w_bubble = 1'b1;
      age++;
    end else begin
      w_bubble  = 1'b0;
      w_i       = m_i;
      w_kill    = mis || e_berr;
      w_load_ok = mem && !m_i.mw && !mis && !e_berr;
      m_i       = ex_i;
      age       = 0;
      dut_stalls = 0;
      ex_i      = (q.size() != 0) ? q.pop_front() : nop();
      drive_ex(ex_i);
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  function automatic instr_t rand_instr();
    instr_t      t;
    logic [2:0]  lds [8];
    logic [31:0] a;
    int          lat, sel, kind;
    lds = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    a = $urandom;
    if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
    sel = int'($urandom_range(0, 9));
    if (sel <= 5)      lat = int'($urandom_range(0, 3));
    else if (sel <= 7) lat = int'($urandom_range(4, TIMEOUT));
    else if (sel == 8) lat = NEVER;
    else               lat = int'(TIMEOUT) + 1;
    kind = int'($urandom_range(0, 3));
    case (kind)
      0: t = mk(1'($urandom), 1'b0, RES_ALU, 2'($urandom), 3'($urandom), a, $urandom, $urandom, lat);
      1: t = mk(1'b1, 1'b0, RES_PC4, 2'($urandom), 3'($urandom), a, $urandom, $urandom, lat);
      2: t = mk(1'b1, 1'b0, RES_MEM, 2'($urandom), lds[$urandom_range(0, 7)], a, $urandom, $urandom, lat);
      default: t = mk(1'b0, 1'b1, RES_ALU, 2'($urandom_range(0, 2)), 3'($urandom), a, $urandom, $urandom, lat);
    endcase
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    instr_t t;
    vectors = 0; errors = 0;
    reset = 1'b1;
    DMemReady = 1'b0; DMemRData = '0;
    ex_i = nop(); drive_ex(ex_i);
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_after_reset();

    // sw 0xDEADBEEF @0x100, zero wait
    t = mk(1'b0, 1'b1, RES_ALU, ST_SW, 3'b000, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    t.lit_st_en = 1'b1; t.lit_wd = 32'hDEAD_BEEF; t.lit_be = 4'b1111; t.lit_stalls = 0;
    q.push_back(t);
    // lb @0x103, ready after 3 cycles
    t = mk(1'b1, 1'b0, RES_MEM, 2'b00, LD_LB, 32'h103, 32'h0, 32'h80FF_0000, 3);
    t.lit_rd_en = 1'b1; t.lit_rd = 32'hFFFF_FF80; t.lit_stalls = 3;
    q.push_back(t);
    // lhu @0x102
    t = mk(1'b1, 1'b0, RES_MEM, 2'b00, LD_LHU, 32'h102, 32'h0, 32'h8001_1234, 1);
    t.lit_rd_en = 1'b1; t.lit_rd = 32'h0000_8001; t.lit_stalls = 1;
    q.push_back(t);
    // sh 0xABCD @0x102
    t = mk(1'b0, 1'b1, RES_ALU, ST_SH, 3'b000, 32'h102, 32'h5555_ABCD, 32'h0, 2);
    t.lit_st_en = 1'b1; t.lit_wd = 32'hABCD_ABCD; t.lit_be = 4'b1100; t.lit_stalls = 2;
    q.push_back(t);
    // lw @0x101: dropped, no stall
    t = mk(1'b1, 1'b0, RES_MEM, 2'b00, LD_LW, 32'h101, 32'h0, 32'h1234_5678, 0);
    t.lit_stalls = 0;
    q.push_back(t);
    // lw with no ready: bus timeout
    t = mk(1'b1, 1'b0, RES_MEM, 2'b00, LD_LW, 32'h200, 32'h0, 32'h0, NEVER);
    t.lit_stalls = int'(TIMEOUT);
    q.push_back(t);
    while (q.size() != 0) cycle();
    drain(int'(TIMEOUT) + 4);

    // randomized back-to-back traffic
    for (int i = 0; i < 300; i++) begin
      q.push_back(rand_instr());
      while (q.size() != 0) cycle();
    end
    drain(int'(TIMEOUT) + 4);

    // reset while waiting on memory
    q.push_back(mk(1'b1, 1'b0, RES_MEM, 2'b00, LD_LW, 32'h300, 32'h0, 32'h0, NEVER));
    drain(4);
    #2;
    chk("pre_reset_StallM", 32'(StallM), 32'd1);
    chk("pre_reset_DMemReq", 32'(DMemReq), 32'd1);
    #1;
    reset = 1'b1;
    DMemReady = 1'b0;
    #1;
    chk_all_zero("async_reset");
    ex_i = nop(); drive_ex(ex_i);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_after_reset();
    t = mk(1'b1, 1'b0, RES_ALU, 2'b00, 3'b000, 32'h0000_0042, 32'h0, 32'h0, 0);
    t.lit_stalls = 0;
    q.push_back(t);
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
